cmlb_miss_ctl: RTL

Code-MLB miss handler sitting directly downstream of the code MLB lookup. It detects a fetch-side lookup miss and stalls the fetch frontend. It issues one page-walk request, waits for the walker response, then writes the returned entry back into the code MLB (or reports a fault), after which the frontend re-issues the lookup and hits.

---
 rtl/cmlb_miss_ctl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cmlb_miss_ctl.sv
// cmlb_miss_ctl: code-MLB miss handler, stalls fetch, issues one page walk and refills the MLB.
// Optional walk-response timeout with DRAIN state under CMLB_MISS_TIMEOUT_EN.
`ifndef cmlbData_width
`define cmlbData_width 64
`endif
module cmlb_miss_ctl #(
  parameter int IP_WIDTH = 65,
  parameter int DATA_WIDTH = `cmlbData_width
`ifdef CMLB_MISS_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lkp_valid,
  input  logic [IP_WIDTH-1:0]   lkp_addr,
  input  logic                  lkp_tr,
  input  logic                  lkp_hit,
  input  logic                  mlb_busy,
  input  logic                  flush,
  output logic                  miss_stall,
  output logic                  walk_req_valid,
  input  logic                  walk_req_ready,
  output logic [IP_WIDTH-1:0]   walk_req_addr,
  output logic                  walk_req_tr,
  input  logic                  walk_rsp_valid,
  input  logic [DATA_WIDTH-1:0] walk_rsp_data,
  input  logic                  walk_rsp_fault,
  output logic                  mlb_wen,
  output logic [IP_WIDTH-1:0]   mlb_addr,
  output logic                  mlb_tr,
  output logic [DATA_WIDTH-1:0] mlb_data,
  output logic                  fault_valid,
  output logic [IP_WIDTH-1:0]   fault_addr,
  output logic                  fault_timeout
);
`ifdef CMLB_MISS_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT, DRAIN} state_t;
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT} state_t;
`endif
  state_t state;
  logic kill, miss;
  assign miss = ~rst & (state == IDLE) & lkp_valid & ~lkp_hit & ~mlb_busy;
  assign miss_stall = (state != IDLE) | miss;
  assign mlb_addr = walk_req_addr;
  assign mlb_tr = walk_req_tr;
  assign fault_addr = walk_req_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kill <= 1'b0;
      walk_req_valid <= 1'b0;
      walk_req_addr <= '0;
      walk_req_tr <= 1'b0;
      mlb_data <= '0;
      mlb_wen <= 1'b0;
      fault_valid <= 1'b0;
      fault_timeout <= 1'b0;
`ifdef CMLB_MISS_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      mlb_wen <= 1'b0;
      fault_valid <= 1'b0;
      fault_timeout <= 1'b0;
      case (state)
        IDLE: if (miss) begin
          state <= REQ;
          walk_req_valid <= 1'b1;
          walk_req_addr <= lkp_addr;
          walk_req_tr <= lkp_tr;
          kill <= 1'b0;
        end
        REQ: begin
          kill <= kill | flush;
          if (walk_req_ready) begin
            state <= WAIT;
            walk_req_valid <= 1'b0;
`ifdef CMLB_MISS_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        // a flush arriving with the response still wins: the entry is dropped
        WAIT: if (walk_rsp_valid) begin
          kill <= 1'b0;
          if (kill | flush) state <= IDLE;
          else if (walk_rsp_fault) begin
            state <= FAULT;
            fault_valid <= 1'b1;
          end else begin
            state <= FILL;
            mlb_data <= walk_rsp_data;
            mlb_wen <= 1'b1;
          end
        end
`ifdef CMLB_MISS_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          kill <= 1'b0;
          if (kill | flush) state <= DRAIN;
          else begin
            state <= FAULT;
            fault_valid <= 1'b1;
            fault_timeout <= 1'b1;
          end
        end else begin
          kill <= kill | flush;
          cnt <= cnt + 1'b1;
        end
`else
        else kill <= kill | flush;
`endif
        FILL: state <= IDLE;
`ifdef CMLB_MISS_TIMEOUT_EN
        // a timed-out walk is still in flight; its late response must be swallowed
        FAULT: state <= fault_timeout ? DRAIN : IDLE;
        DRAIN: if (walk_rsp_valid) state <= IDLE;
`else
        FAULT: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
